// File: rtl/system_status.sv
// Board clock divider and status block: fractional UART oversampling strobe,
// 1 kHz housekeeping tick, mode-selectable status LED and activity-hold LEDs.
module system_status #(
  parameter int unsigned CLKRATE    = 1_789_773,
  parameter int unsigned BAUDRATE   = 9600,
  parameter int unsigned OVERSAMPLE = 6,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned NUM_ACT    = 2,
  parameter int unsigned PERSIST_MS = 31,
  parameter int unsigned BLINK_MS   = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_ACT-1:0] act_in,
  input  logic [1:0]         led_mode,
  output logic               uart_clk,
  output logic               tick_1khz,
  output logic               blink,
  output logic [NUM_ACT-1:0] act_led
);

  typedef enum logic [1:0] {
    LED_BLINK = 2'b00,
    LED_ON    = 2'b01,
    LED_OFF   = 2'b10,
    LED_HEART = 2'b11
  } led_mode_e;

  // Rounded phase increment: (2*num + den) / (2*den) == round(num/den).
  localparam longint unsigned NCO_NUM  = 64'(BAUDRATE) * 64'(OVERSAMPLE) * (64'd1 << ACC_W);
  localparam longint unsigned INC_CALC = (64'd2 * NCO_NUM + 64'(CLKRATE)) / (64'd2 * 64'(CLKRATE));
  localparam logic [ACC_W-1:0] INC     = ACC_W'(INC_CALC);

  localparam int unsigned KHZ_DIV = CLKRATE / 1000;
  localparam int unsigned KHZ_W   = (KHZ_DIV > 1) ? $clog2(KHZ_DIV) : 1;
  localparam int unsigned MS_W    = $clog2(BLINK_MS);
  localparam int unsigned CNT_W   = $clog2(PERSIST_MS + 1);

  localparam logic [KHZ_W-1:0] KHZ_RELOAD = KHZ_W'(KHZ_DIV - 1);
  localparam logic [MS_W-1:0]  MS_LAST    = MS_W'(BLINK_MS - 1);
  localparam logic [MS_W-1:0]  MS_HALF    = MS_W'(BLINK_MS / 2);
  localparam logic [MS_W-1:0]  MS_100     = MS_W'(100);
  localparam logic [MS_W-1:0]  MS_200     = MS_W'(200);
  localparam logic [MS_W-1:0]  MS_300     = MS_W'(300);
  localparam logic [CNT_W-1:0] PERSIST    = CNT_W'(PERSIST_MS);

  if (64'(OVERSAMPLE) * 64'(BAUDRATE) >= 64'(CLKRATE / 2)) begin : g_bad_baud
    $fatal(1, "system_status: OVERSAMPLE*BAUDRATE must be below CLKRATE/2");
  end
  if (CLKRATE < 1000) begin : g_bad_clk
    $fatal(1, "system_status: CLKRATE must be at least 1000");
  end
  if (BLINK_MS < 300) begin : g_bad_blink
    $fatal(1, "system_status: BLINK_MS must be at least 300");
  end
  if (PERSIST_MS < 1) begin : g_bad_persist
    $fatal(1, "system_status: PERSIST_MS must be at least 1");
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             uart_q, uart_d;
  logic [KHZ_W-1:0] khz_cnt_q, khz_cnt_d;
  logic             tick_q, tick_d;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic             blink_q, blink_d;
  led_mode_e        mode;

  logic [NUM_ACT-1:0] s0_q, s1_q, s2_q;
  logic [NUM_ACT-1:0] edge_det;
  logic [CNT_W-1:0]   cnt_q [NUM_ACT];
  logic [CNT_W-1:0]   cnt_d [NUM_ACT];
  logic [NUM_ACT-1:0] act_led_q, act_led_d;

  assign mode = led_mode_e'(led_mode);

  always_comb begin
    {uart_d, acc_d} = {1'b0, acc_q} + {1'b0, INC};
  end

  always_comb begin
    tick_d    = (khz_cnt_q == '0);
    khz_cnt_d = tick_d ? KHZ_RELOAD : khz_cnt_q - KHZ_W'(1);
  end

  always_comb begin
    ms_d = ms_q;
    if (tick_q) begin
      ms_d = (ms_q == MS_LAST) ? '0 : ms_q + MS_W'(1);
    end
  end

  always_comb begin
    blink_d = 1'b0;
    unique case (mode)
      LED_BLINK: blink_d = (ms_q < MS_HALF);
      LED_ON:    blink_d = 1'b1;
      LED_OFF:   blink_d = 1'b0;
      LED_HEART: blink_d = (ms_q < MS_100) || ((ms_q >= MS_200) && (ms_q < MS_300));
    endcase
  end

  // A fresh edge reloads the hold counter even when a tick would decrement it.
  always_comb begin
    edge_det  = s1_q ^ s2_q;
    cnt_d     = cnt_q;
    act_led_d = '0;
    for (int unsigned i = 0; i < NUM_ACT; i++) begin
      act_led_d[i] = (cnt_q[i] != '0);
      if (edge_det[i]) begin
        cnt_d[i] = PERSIST;
      end else if (tick_q && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      uart_q    <= 1'b0;
      khz_cnt_q <= KHZ_RELOAD;
      tick_q    <= 1'b0;
      ms_q      <= '0;
      blink_q   <= 1'b0;
      s0_q      <= '1;
      s1_q      <= '1;
      s2_q      <= '1;
      act_led_q <= '0;
      for (int unsigned i = 0; i < NUM_ACT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      acc_q     <= acc_d;
      uart_q    <= uart_d;
      khz_cnt_q <= khz_cnt_d;
      tick_q    <= tick_d;
      ms_q      <= ms_d;
      blink_q   <= blink_d;
      s0_q      <= act_in;
      s1_q      <= s0_q;
      s2_q      <= s1_q;
      act_led_q <= act_led_d;
      for (int unsigned i = 0; i < NUM_ACT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign uart_clk  = uart_q;
  assign tick_1khz = tick_q;
  assign blink     = blink_q;
  assign act_led   = act_led_q;

endmodule

// File: tb/tb_system_status.sv
// Randomised bench for system_status, scaled-down clock so full blink periods fit;
// expectations come from closed-form edge-count arithmetic.
module tb_system_status;

  localparam int CLKRATE    = 25_000;
  localparam int BAUDRATE   = 300;
  localparam int OVERSAMPLE = 6;
  localparam int ACC_W      = 12;
  localparam int NUM_ACT    = 2;
  localparam int PERSIST_MS = 31;
  localparam int BLINK_MS   = 1000;

  localparam longint K    = CLKRATE / 1000;
  localparam longint P    = PERSIST_MS;
  localparam longint BMS  = BLINK_MS;
  localparam longint WRAP = 64'd1 << ACC_W;
  localparam longint PH1  = 38000;
  localparam longint PH2  = 5000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_ACT-1:0] act_in = '1;
  logic [1:0]         led_mode = 2'b00;
  logic               uart_clk, tick_1khz, blink;
  logic [NUM_ACT-1:0] act_led;

  system_status #(
    .CLKRATE(CLKRATE), .BAUDRATE(BAUDRATE), .OVERSAMPLE(OVERSAMPLE), .ACC_W(ACC_W),
    .NUM_ACT(NUM_ACT), .PERSIST_MS(PERSIST_MS), .BLINK_MS(BLINK_MS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .act_in(act_in), .led_mode(led_mode),
    .uart_clk(uart_clk), .tick_1khz(tick_1khz), .blink(blink), .act_led(act_led)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: n = rising edges since reset release; c1/c2 = edges at which
  // each line was last seen to change (0 = never).
  longint             n = 0;
  longint             inc;
  logic [NUM_ACT-1:0] a_prev = '1;
  longint             c1 [NUM_ACT];
  longint             c2 [NUM_ACT];

  longint first_uart = 0, last_uart = 0, uart_cnt = 0, tick_cnt = 0, rise0 = 0;
  longint post_act = 0;
  bit     phase2 = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at edge %0d", tag, got, exp, n);
    end
  endtask

  function automatic longint ticks_upto(input longint m);
    return (m <= 0) ? 0 : m / K;
  endfunction

  function automatic longint ms_after(input longint m);
    return (m <= 0) ? 0 : ((m - 1) / K) % BMS;
  endfunction

  function automatic logic blink_ref(input longint ms, input logic [1:0] mode);
    case (mode)
      2'b00:   return ms < BMS / 2;
      2'b01:   return 1'b1;
      2'b10:   return 1'b0;
      default: return (ms < 100) || (ms >= 200 && ms < 300);
    endcase
  endfunction

  // Hold count after edge m: a change sampled at edge c reloads at edge c+2,
  // then loses one per tick seen from the reload edge onward.
  function automatic longint hold_ref(input int ch, input longint m);
    longint r, d;
    r = -1;
    if (c1[ch] > 0 && c1[ch] + 2 <= m)      r = c1[ch] + 2;
    else if (c2[ch] > 0 && c2[ch] + 2 <= m) r = c2[ch] + 2;
    if (m <= 0 || r < 0) return 0;
    d = ticks_upto(m - 1) - ticks_upto(r - 1);
    return (d >= P) ? 0 : P - d;
  endfunction

  task automatic cycle();
    logic [1:0]         mode_at;
    logic [NUM_ACT-1:0] led_exp;
    logic               u_exp, t_exp;
    @(posedge clk);
    mode_at = led_mode;
    if (!rst_n) begin
      n = 0;
      a_prev = '1;
      last_uart = 0;
      for (int ch = 0; ch < NUM_ACT; ch++) begin c1[ch] = 0; c2[ch] = 0; end
    end else begin
      n++;
      for (int ch = 0; ch < NUM_ACT; ch++) begin
        if (act_in[ch] !== a_prev[ch]) begin c2[ch] = c1[ch]; c1[ch] = n; end
      end
      a_prev = act_in;
    end
    #1;
    if (!rst_n) begin
      check_eq("rst_outs", {uart_clk, tick_1khz, blink, act_led}, '0);
    end else begin
      u_exp = ((n * inc) / WRAP) != (((n - 1) * inc) / WRAP);
      t_exp = (n >= K) && (n % K == 0);
      for (int ch = 0; ch < NUM_ACT; ch++) led_exp[ch] = hold_ref(ch, n - 1) != 0;
      check_eq("uart_clk", uart_clk, u_exp);
      check_eq("tick_1khz", tick_1khz, t_exp);
      check_eq("blink", blink, blink_ref(ms_after(n - 1), mode_at));
      check_eq("act_led", act_led, led_exp);
      if (uart_clk === 1'b1) begin
        if (first_uart == 0) first_uart = n;
        if (last_uart > 0)
          check_eq("nco_gap", (n - last_uart == WRAP / inc) || (n - last_uart == WRAP / inc + 1), 1);
        last_uart = n;
        if (n <= WRAP) uart_cnt++;
      end
      if (tick_1khz === 1'b1 && n <= 10 * K) tick_cnt++;
      if (act_led[0] === 1'b1 && rise0 == 0) rise0 = n;
      if (phase2 && act_led !== '0) post_act++;
    end
  endtask

  initial begin
    longint nx, pulse_end, last0, last1, retrig_m;
    bit     armed;
    inc = longint'($rtoi(real'(BAUDRATE) * real'(OVERSAMPLE) * real'(WRAP) / real'(CLKRATE) + 0.5));
    for (int ch = 0; ch < NUM_ACT; ch++) begin c1[ch] = 0; c2[ch] = 0; end
    pulse_end = 0; last0 = 0; last1 = 0; retrig_m = 0; armed = 1'b0;

    repeat (3) cycle();
    @(negedge clk) rst_n = 1'b1;

    for (longint i = 0; i < PH1; i++) begin
      nx = n + 1;
      if (nx == 26000) led_mode = 2'b01;
      if (nx == 26500) led_mode = 2'b10;
      if (nx == 27000) led_mode = 2'b11;
      if (nx >= 35000 && nx < PH1 - 300 && $urandom_range(0, 299) == 0)
        led_mode = 2'($urandom_range(0, 3));
      if (nx == PH1 - 300) led_mode = 2'b01;

      if (nx == 5000) begin act_in[0] = 1'b0; last0 = nx; end
      if (nx == 5005) begin act_in[0] = 1'b1; last0 = nx; end
      if (nx == 8000) begin act_in[0] = 1'b0; last0 = nx; armed = 1'b1; end
      // Land the re-trigger edge on the same cycle as a tick while the hold is 3.
      if (armed && nx > 8000 && ((nx + 1) % K == 0) && hold_ref(0, nx + 1) == 3) begin
        act_in[0] = 1'b1; last0 = nx; armed = 1'b0; retrig_m = nx + 1;
      end

      if (pulse_end != 0 && nx >= pulse_end) begin
        act_in[0] = 1'b1; last0 = nx; pulse_end = 0;
      end else if (nx >= 12000 && nx < PH1 - 500) begin
        if (act_in[0] && nx - last0 >= 5 && $urandom_range(0, 1499) == 0) begin
          act_in[0] = 1'b0; last0 = nx; pulse_end = nx + longint'($urandom_range(5, 40));
        end
      end
      if (nx >= 12000 && nx < PH1 - 500 && nx - last1 >= 5 && $urandom_range(0, 2999) == 0) begin
        act_in[1] = ~act_in[1]; last1 = nx;
      end
      if (nx == PH1 - 200) begin act_in[0] = ~act_in[0]; last0 = nx; end

      cycle();
      if (retrig_m != 0 && n == retrig_m + 4 * K) check_eq("retrig_hold", act_led[0], 1'b1);
    end

    check_eq("nco_first", first_uart, (WRAP + inc - 1) / inc);
    check_eq("nco_count", uart_cnt, inc);
    check_eq("khz_count", tick_cnt, 10);
    check_eq("act_rise", rise0, 5003);
    check_eq("retrig_hit", retrig_m != 0, 1);
    check_eq("hold_before_rst", act_led[0], 1'b1);
    check_eq("blink_before_rst", blink, 1'b1);

    #2;
    act_in = '1;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", {uart_clk, tick_1khz, blink, act_led}, '0);
    repeat (3) cycle();
    @(negedge clk) rst_n = 1'b1;
    phase2 = 1'b1;
    for (longint i = 0; i < PH2; i++) cycle();
    check_eq("post_rst_act", post_act, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/system_status.md
# system_status

Parametrised clock-divider and status-indicator block: generates the UART oversampling strobe, a 1 kHz housekeeping tick, a mode-selectable status LED and N independent activity-persistence LEDs. It sits between the board clock and the UART/LED pins at the top level, with the UART receiver and the status LED drivers as its loads. Relative to the fixed single-channel divider it adds a fractional (phase-accumulator) baud generator, multiple activity channels, selectable LED modes and an asynchronous reset.

## Interface

- CLKRATE, 1_789_773, system clock frequency in Hz
- BAUDRATE, 9600, serial bit rate
- OVERSAMPLE, 6, uart_clk strobes per bit
- ACC_W, 16, phase-accumulator width
- NUM_ACT, 2, number of activity channels
- PERSIST_MS, 31, activity LED hold time in ms
- BLINK_MS, 1000, status LED period in ms (>= 300)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- act_in  in  NUM_ACT  asynchronous activity inputs (idle high, e.g. RX lines)
- led_mode  in  2  status LED mode: 00 blink, 01 on, 10 off, 11 heartbeat
- uart_clk  out  1  one-cycle strobe at OVERSAMPLE×BAUDRATE (average)
- tick_1khz  out  1  one-cycle strobe every CLKRATE/1000 clocks
- blink  out  1  status LED
- act_led  out  NUM_ACT  per-channel activity LED

## Operation

- Reset is asynchronous on the falling edge of rst_n; release is synchronous to clk. While rst_n=0: uart_clk=0, tick_1khz=0, blink=0, act_led=0, acc=0, khz_cnt=KHZ_DIV-1, ms_cnt=0, persistence counters=0, all sync flops=1.
- Baud NCO: INC = round(BAUDRATE×OVERSAMPLE×2^ACC_W / CLKRATE); default 2109. Each clock, {carry,acc} <= acc + INC (mod 2^ACC_W); uart_clk <= carry. Long-run rate is exact to within 1 pulse per 2^ACC_W clocks; inter-pulse spacing is floor or ceil of 2^ACC_W/INC (31 or 32 clocks by default).
- 1 kHz: KHZ_DIV = CLKRATE/1000 (integer, 1789). khz_cnt decrements; when 0 it reloads KHZ_DIV-1. tick_1khz <= (khz_cnt==0).
- ms counter: on tick_1khz, ms_cnt increments and wraps from BLINK_MS-1 to 0.
- blink is registered from ms_cnt and led_mode:
  - 00: ms_cnt < BLINK_MS/2.
  - 01: 1.
  - 10: 0.
  - 11: ms_cnt < 100 or 200 <= ms_cnt < 300.
  - A led_mode change takes effect on the next clock. ms_cnt is not reset by a mode change.
- Activity channel i (independent per channel):
  - 3-flop chain s0 <= act_in[i], s1 <= s0, s2 <= s1.
  - edge = s1 != s2.
  - On edge, cnt <= PERSIST_MS. Otherwise, if tick_1khz and cnt != 0, cnt <= cnt-1.
  - Edge reload wins over a simultaneous tick decrement.
  - act_led[i] <= (cnt != 0).
  - cnt width is $clog2(PERSIST_MS+1).
- Sync flops reset to 1, so an idle-high line produces no spurious edge after reset. A line held low through reset produces exactly one edge after release.
- Elaboration checks (fatal): OVERSAMPLE×BAUDRATE < CLKRATE/2; CLKRATE >= 1000; BLINK_MS >= 300; PERSIST_MS >= 1.

## Timing

- All outputs are registered; no combinational path from input to output.
- uart_clk: first pulse at the first clock where acc wraps. With the default INC, that is the 32nd rising edge after reset release (ceil(65536/2109)=32). Always a single-cycle pulse.
- tick_1khz: first high in the cycle after the KHZ_DIV-th rising edge following release, then every KHZ_DIV clocks. Always a single-cycle pulse.
- blink follows ms_cnt by 1 clock.
- act_in to act_led latency: an act_in transition meeting setup before edge E1 gives act_led=1 after E4 (4 clocks).
- act_led hold after the last edge: between PERSIST_MS-1 and PERSIST_MS ms plus 1 clock, depending on tick phase.
- Reset mid-operation: all state returns to reset values immediately. Any in-progress persistence is discarded and act_led drops asynchronously.

## Test plan

- Reset/NCO: release rst_n, run 65536 clocks -> exactly 2109 uart_clk pulses; first pulse after edge 32; every spacing is 31 or 32 clocks.
- 1 kHz: run 10×1789 clocks -> exactly 10 tick_1khz pulses at intervals of 1789; blink in mode 00 is high for ms 0..499 and low for ms 500..999.
- Modes: step led_mode through 01, 10, 11 -> blink constant 1, then constant 0 one clock after each change; mode 11 gives high windows of 100 ms at ms 0 and ms 200 per 1000 ms.
- Activity: single low pulse of 5 clocks on act_in[0] -> act_led[0] rises 4 clocks after the falling edge, holds 30–31 ms, then returns to 0; act_led[1] stays 0 throughout.
- Retrigger/simultaneity: drive an edge that is detected in the same cycle as tick_1khz while cnt=3 -> cnt becomes PERSIST_MS (31), not 2.
- Async reset mid-hold: assert rst_n=0 while act_led[0]=1 -> act_led=0, blink=0, uart_clk=0 with no clock edge. With act_in held high across release, there are no activity pulses afterwards.
